// File: rtl/nmos_lb_pkg.sv
// Shared helpers for the nmos_lib two-phase dynamic register family.
// Sizes the per-stage leak counters.
package nmos_lb_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Width of a stage's age counter.
  // The counter must be able to hold DECAY itself.
  function automatic int age_width(input int decay);
    int w;
    w = (decay > 0) ? clog2(decay + 1) : 1;
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/nmos_lbn_sreg_if.sv
// Control/data bundle of the nmos_lbn_sreg dynamic register chain.
// The master drives phases, loads and shift inputs; the slave returns the node views and flags.
interface nmos_lbn_sreg_if #(
  parameter int WIDTH = 8,
  parameter int NLOAD = 2,
  parameter int DEPTH = 1
);
  logic                     c1;
  logic                     c2;
  logic [NLOAD-1:0]         ld;
  logic [NLOAD*WIDTH-1:0]   d;
  logic                     sh_en;
  logic [WIDTH-1:0]         sh_in;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         q_n;
  logic [DEPTH*WIDTH-1:0]   taps;
  logic                     ld_multi;
  logic                     phase_err;
  logic [DEPTH-1:0]         decayed;

  modport master (
    output c1, c2, ld, d, sh_en, sh_in,
    input  q, q_n, taps, ld_multi, phase_err, decayed
  );

  modport slave (
    input  c1, c2, ld, d, sh_en, sh_in,
    output q, q_n, taps, ld_multi, phase_err, decayed
  );
endinterface

// File: rtl/nmos_lb_stage.sv
// One PHI2/PHI1 pass-transistor stage.
// The PHI2 node can leak to zero when it is left unrefreshed.
module nmos_lb_stage
  import nmos_lb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DECAY = 0
) (
  input  logic             main_clk,
  input  logic             main_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             c1,
  output logic [WIDTH-1:0] n1,
  output logic             decayed
);

  logic [WIDTH-1:0] n2;
  logic             leak_hit;

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      n2 <= '0;
      n1 <= '0;
    end else begin
      if (wr_en) begin
        n2 <= wr_data;
      end else if (leak_hit) begin
        n2 <= '0;
      end
      if (c1) begin
        n1 <= n2;
      end
    end
  end

  generate
    if (DECAY > 0) begin : g_leak
      localparam int AW = age_width(DECAY);
      logic [AW-1:0] age;
      logic          decayed_r;

      // The leak fires on the single edge where the age counter reaches DECAY.
      // Once the counter saturates, the node is already zero.
      assign leak_hit = !wr_en && (age == AW'(DECAY - 1));
      assign decayed  = decayed_r;

      always_ff @(posedge main_clk) begin
        if (main_rst) begin
          age       <= '0;
          decayed_r <= 1'b0;
        end else if (wr_en) begin
          age       <= '0;
          decayed_r <= 1'b0;
        end else begin
          if (age != AW'(DECAY)) begin
            age <= age + AW'(1);
          end
          if (leak_hit) begin
            decayed_r <= 1'b1;
          end
        end
      end
    end else begin : g_no_leak
      assign leak_hit = 1'b0;
      assign decayed  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/nmos_lbn_sreg.sv
// Multi-bit, multi-load two-phase NMOS dynamic register / shift chain.
// The load logic drives stage 0, and DEPTH stages are chained PHI2 -> PHI1.
module nmos_lbn_sreg
  import nmos_lb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NLOAD = 2,
  parameter int DEPTH = 1,
  parameter int DECAY = 0
) (
  input  logic                 main_clk,
  input  logic                 main_rst,
  nmos_lbn_sreg_if.slave       bus
);

  logic [WIDTH-1:0] n1      [DEPTH];
  logic [WIDTH-1:0] wr_data [DEPTH];
  logic             wr_en   [DEPTH];
  logic [WIDTH-1:0] ld_data;
  logic             any_ld;
  logic             ld_multi_r;
  logic             phase_err_r;

  // Simultaneous loads wire-OR onto the PHI2 node of stage 0.
  always_comb begin
    ld_data = '0;
    for (int i = 0; i < NLOAD; i++) begin
      ld_data = ld_data | (bus.d[i*WIDTH +: WIDTH] & {WIDTH{bus.ld[i]}});
    end
  end

  assign any_ld = |bus.ld;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign wr_en[k]   = any_ld | bus.c2;
        assign wr_data[k] = any_ld    ? ld_data :
                            bus.sh_en ? bus.sh_in : n1[k];
      end else begin : g_body
        assign wr_en[k]   = bus.c2;
        assign wr_data[k] = bus.sh_en ? n1[k-1] : n1[k];
      end

      nmos_lb_stage #(
        .WIDTH (WIDTH),
        .DECAY (DECAY)
      ) u_stage (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .wr_en    (wr_en[k]),
        .wr_data  (wr_data[k]),
        .c1       (bus.c1),
        .n1       (n1[k]),
        .decayed  (bus.decayed[k])
      );

      assign bus.taps[k*WIDTH +: WIDTH] = n1[k];
    end
  endgenerate

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      ld_multi_r  <= 1'b0;
      phase_err_r <= 1'b0;
    end else begin
      ld_multi_r  <= ($countones(bus.ld) > 1);
      phase_err_r <= bus.c1 & bus.c2;
    end
  end

  assign bus.q         = n1[DEPTH-1];
  assign bus.q_n       = ~n1[DEPTH-1];
  assign bus.ld_multi  = ld_multi_r;
  assign bus.phase_err = phase_err_r;

endmodule

// File: tb/tb_nmos_lbn_sreg.sv
// Self-checking bench for nmos_lbn_sreg (WIDTH=8, NLOAD=2, DEPTH=3, DECAY=4).
// It combines a vector table, hand sequences and a randomized reference-model run.
module tb_nmos_lbn_sreg;
  localparam int WIDTH = 8;
  localparam int NLOAD = 2;
  localparam int DEPTH = 3;
  localparam int DECAY = 4;

  logic main_clk;
  logic main_rst;
  int   checks;
  int   failures;

  nmos_lbn_sreg_if #(.WIDTH(WIDTH), .NLOAD(NLOAD), .DEPTH(DEPTH)) bus ();

  nmos_lbn_sreg #(
    .WIDTH (WIDTH),
    .NLOAD (NLOAD),
    .DEPTH (DEPTH),
    .DECAY (DECAY)
  ) dut (
    .main_clk (main_clk),
    .main_rst (main_rst),
    .bus      (bus.slave)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: the node values of each stage, with an explicit age count.
  logic [7:0] m_n2 [DEPTH];
  logic [7:0] m_n1 [DEPTH];
  int         m_age [DEPTH];
  bit         m_dec [DEPTH];
  bit         m_ldm;
  bit         m_perr;

  task automatic modelStep(input bit rst, input bit c1, input bit c2, input logic [1:0] ld,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input bit sh_en, input logic [7:0] sh_in);
    logic [7:0] nn2 [DEPTH];
    logic [7:0] nn1 [DEPTH];
    logic [7:0] val;
    logic [7:0] ldval;
    bit         wr;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_n2[k] = '0; m_n1[k] = '0; m_age[k] = 0; m_dec[k] = 0;
      end
      m_ldm = 0; m_perr = 0;
      return;
    end
    ldval = (ld[0] ? d0 : 8'h00) | (ld[1] ? d1 : 8'h00);
    for (int k = 0; k < DEPTH; k++) begin
      wr  = 0;
      val = '0;
      if (k == 0 && ld != 2'b00) begin
        wr = 1; val = ldval;
      end else if (c2) begin
        wr = 1;
        if (!sh_en) val = m_n1[k];
        else if (k == 0) val = sh_in;
        else val = m_n1[k-1];
      end
      nn1[k] = c1 ? m_n2[k] : m_n1[k];
      if (wr) begin
        nn2[k] = val; m_age[k] = 0; m_dec[k] = 0;
      end else begin
        nn2[k] = m_n2[k];
        if (m_age[k] < DECAY) begin
          m_age[k] = m_age[k] + 1;
          if (m_age[k] == DECAY) begin
            nn2[k] = '0; m_dec[k] = 1;
          end
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      m_n2[k] = nn2[k]; m_n1[k] = nn1[k];
    end
    m_ldm  = (ld == 2'b11);
    m_perr = c1 & c2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_q", {24'h0, bus.q}, {24'h0, m_n1[DEPTH-1]});
    checkOutput("model_q_n", {24'h0, bus.q_n}, {24'h0, ~m_n1[DEPTH-1]});
    checkOutput("model_taps", {8'h0, bus.taps}, {8'h0, m_n1[2], m_n1[1], m_n1[0]});
    checkOutput("model_ld_multi", {31'h0, bus.ld_multi}, {31'h0, m_ldm});
    checkOutput("model_phase_err", {31'h0, bus.phase_err}, {31'h0, m_perr});
    checkOutput("model_decayed", {29'h0, bus.decayed}, {29'h0, m_dec[2], m_dec[1], m_dec[0]});
  endtask

  task automatic applyStimulus(input bit rst, input bit c1, input bit c2, input logic [1:0] ld,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input bit sh_en, input logic [7:0] sh_in);
    @(negedge main_clk);
    main_rst  = rst;
    bus.c1    = c1;
    bus.c2    = c2;
    bus.ld    = ld;
    bus.d     = {d1, d0};
    bus.sh_en = sh_en;
    bus.sh_in = sh_in;
    @(posedge main_clk);
    modelStep(rst, c1, c2, ld, d0, d1, sh_en, sh_in);
    #1;
    checkModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
  endtask

  typedef struct {
    bit         rst;
    bit         c1;
    bit         c2;
    logic [1:0] ld;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         sh_en;
    logic [7:0] sh_in;
    logic [7:0] tap0;
    bit         ldm;
    bit         perr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    checks    = 0;
    failures  = 0;
    main_rst  = 1'b1;
    bus.c1    = 1'b0;
    bus.c2    = 1'b0;
    bus.ld    = '0;
    bus.d     = '0;
    bus.sh_en = 1'b0;
    bus.sh_in = '0;

    //            rst c1 c2 ld     d0     d1     sh  sh_in  tap0   ldm perr
    vecs[0]  = '{1, 1, 1, 2'b11, 8'hA5, 8'h0F, 0, 8'h00, 8'h00, 0, 0};
    vecs[1]  = '{0, 0, 0, 2'b11, 8'hA5, 8'h0F, 0, 8'h00, 8'h00, 1, 0};
    vecs[2]  = '{0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'hAF, 0, 0};
    vecs[3]  = '{0, 0, 0, 2'b01, 8'h02, 8'h77, 0, 8'h00, 8'hAF, 0, 0};
    vecs[4]  = '{0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h02, 0, 0};
    vecs[5]  = '{0, 0, 0, 2'b01, 8'h01, 8'h00, 0, 8'h00, 8'h02, 0, 0};
    vecs[6]  = '{0, 1, 1, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0, 1};
    vecs[7]  = '{0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0, 0};
    vecs[8]  = '{0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h02, 0, 0};
    vecs[9]  = '{0, 0, 1, 2'b10, 8'h3C, 8'hC3, 1, 8'h55, 8'h02, 0, 0};
    vecs[10] = '{0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'hC3, 0, 0};
    vecs[11] = '{1, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].c1, vecs[i].c2, vecs[i].ld, vecs[i].d0,
                    vecs[i].d1, vecs[i].sh_en, vecs[i].sh_in);
      checkOutput($sformatf("vec%0d_tap0", i), {24'h0, bus.taps[7:0]}, {24'h0, vecs[i].tap0});
      checkOutput($sformatf("vec%0d_ld_multi", i), {31'h0, bus.ld_multi}, {31'h0, vecs[i].ldm});
      checkOutput($sformatf("vec%0d_phase_err", i), {31'h0, bus.phase_err}, {31'h0, vecs[i].perr});
      if (vecs[i].rst) begin
        checkOutput("reset_q", {24'h0, bus.q}, 32'h00);
        checkOutput("reset_q_n", {24'h0, bus.q_n}, 32'hFF);
        checkOutput("reset_decayed", {29'h0, bus.decayed}, 32'h0);
      end
    end

    // Shift three bytes through the chain.
    applyStimulus(1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 1, 2'b00, 8'h00, 8'h00, 1, 8'h11);
    applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 1, 8'h00);
    applyStimulus(0, 0, 1, 2'b00, 8'h00, 8'h00, 1, 8'h22);
    applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 1, 8'h00);
    applyStimulus(0, 0, 1, 2'b00, 8'h00, 8'h00, 1, 8'h33);
    applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 1, 8'h00);
    checkOutput("shift_taps", {8'h0, bus.taps}, {8'h0, 24'h112233});
    checkOutput("shift_q", {24'h0, bus.q}, 32'h11);

    // Recirculate a loaded byte in stage 0.
    applyStimulus(1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 0, 2'b01, 8'h3C, 8'h00, 0, 8'h00);
    applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 2'b00, 8'h00, 8'h00, 0, 8'hEE);
      applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
      checkOutput($sformatf("recirc%0d_tap0", i), {24'h0, bus.taps[7:0]}, 32'h3C);
    end

    // Leak: stage 0 decays after DECAY cycles without a write.
    applyStimulus(1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 0, 2'b01, 8'hFF, 8'h00, 0, 8'h00);
    idle(3);
    checkOutput("leak_early_decayed0", {31'h0, bus.decayed[0]}, 32'h0);
    idle(1);
    checkOutput("leak_decayed0", {31'h0, bus.decayed[0]}, 32'h1);
    applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    checkOutput("leak_tap0", {24'h0, bus.taps[7:0]}, 32'h00);
    applyStimulus(0, 0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    checkOutput("leak_cleared_decayed0", {31'h0, bus.decayed[0]}, 32'h0);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
